// File: rtl/ad_ch_demux_pkg.sv
// Shared constants and the FIFO entry layout for the AD7606 channel demux.
package ad_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned CH_IDX_W = 3;

  typedef struct packed {
    logic                sof;
    logic [CH_IDX_W-1:0] ch;
    logic [DATA_W-1:0]   data;
  } fifo_entry_t;

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ad_ch_demux_sync_fifo.sv
// First-word fall-through synchronous FIFO. Head entry is read combinationally
// from registered storage; push while full is accepted only if a pop happens
// in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ad_ch_demux.sv
// Tags the serial per-channel sample stream from the AD7606 read controller
// with channel index and start-of-frame, filters by channel mask, buffers in
// a FWFT FIFO and tracks frame count, drops and resync errors.
module ad_ch_demux
  import ad_pkg::*;
#(
  parameter int unsigned       GAP_MAX    = 12,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [NUM_CH-1:0] CH_MASK    = 8'hFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_flag,
  input  logic                clr_err,
  output logic [DATA_W-1:0]   out_data,
  output logic [CH_IDX_W-1:0] out_ch,
  output logic                out_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          drop_cnt,
  output logic                ovf_err,
  output logic                frag_err
);

  localparam int unsigned GW = $clog2(GAP_MAX + 1);

  logic [CH_IDX_W-1:0] r_ch_idx;
  logic [GW-1:0]       r_gap_cnt;
  logic [15:0]         r_frame_cnt;
  logic [7:0]          r_drop_cnt;
  logic                r_ovf_err;
  logic                r_frag_err;

  logic                w_timeout;
  logic                w_last_ch;
  logic                w_push_req;
  logic                w_pop;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  fifo_entry_t         w_din;
  fifo_entry_t         w_dout;

  // A flag in the timeout cycle wins, so the resync only fires on idle cycles.
  assign w_timeout  = !in_flag && (r_gap_cnt == GW'(GAP_MAX)) && (r_ch_idx != '0);
  assign w_last_ch  = (r_ch_idx == CH_IDX_W'(NUM_CH - 1));
  assign w_push_req = in_flag && CH_MASK[r_ch_idx];
  assign w_pop      = out_ready && !w_empty;
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Entry for the incoming sample, tagged with the current channel.
  always_comb begin
    w_din      = '0;
    w_din.sof  = (r_ch_idx == '0);
    w_din.ch   = r_ch_idx;
    w_din.data = in_data;
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // Head presentation; forced to zero when empty since storage is not reset.
  always_comb begin
    out_valid = !w_empty;
    out_data  = '0;
    out_ch    = '0;
    out_sof   = 1'b0;
    if (!w_empty) begin
      out_data = w_dout.data;
      out_ch   = w_dout.ch;
      out_sof  = w_dout.sof;
    end
  end

  // Channel counter, gap timer and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_idx    <= '0;
      r_gap_cnt   <= '0;
      r_frame_cnt <= '0;
    end else if (in_flag) begin
      r_gap_cnt <= '0;
      r_ch_idx  <= w_last_ch ? '0 : r_ch_idx + CH_IDX_W'(1);
      if (w_last_ch) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end else begin
      if (r_gap_cnt != GW'(GAP_MAX)) begin
        r_gap_cnt <= r_gap_cnt + GW'(1);
      end
      if (w_timeout) begin
        r_ch_idx <= '0;
      end
    end
  end

  // Sticky errors and drop counter; an event in the clear cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
      r_ovf_err  <= 1'b0;
      r_frag_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf_err  <= 1'b1;
        r_drop_cnt <= clr_err ? 8'd1 : ((r_drop_cnt == '1) ? '1 : r_drop_cnt + 8'd1);
      end else if (clr_err) begin
        r_ovf_err  <= 1'b0;
        r_drop_cnt <= '0;
      end
      if (w_timeout) begin
        r_frag_err <= 1'b1;
      end else if (clr_err) begin
        r_frag_err <= 1'b0;
      end
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign ovf_err   = r_ovf_err;
  assign frag_err  = r_frag_err;

endmodule

// File: doc/ad_ch_demux.md
Name: ad_ch_demux

Overview:
- Sits directly downstream of the AD7606 read controller.
- Consumes the serial per-channel sample stream (16-bit sample plus a one-cycle data_flag per channel, CH1..CH8 in order) and tags each sample with its channel index and a start-of-frame marker.
- Filters samples by a channel mask and buffers them in a small FIFO.
- Presents them to the filter stage over a valid/ready handshake; frame-gap timeout resynchronises the channel counter.

Parameters:
- NUM_CH, 8: channels per conversion frame.
- DATA_W, 16: sample width.
- GAP_MAX, 12: idle cycles after a flag at which the channel counter is forced back to 0. In-frame flag spacing is 4 cycles; inter-frame spacing is >30 cycles.
- FIFO_DEPTH, 16: buffer entries, power of two.
- CH_MASK, 8'hFF: bit n=1 forwards channel n.

Ports:
- clk, in, 1: system clock, 50 MHz.
- rst, in, 1: synchronous reset, active-high.
- in_data, in, DATA_W: sample from the read controller.
- in_flag, in, 1: one-cycle strobe, in_data valid.
- clr_err, in, 1: clears sticky error flags and drop_cnt.
- out_data, out, DATA_W: buffered sample.
- out_ch, out, 3: channel index 0..NUM_CH-1.
- out_sof, out, 1: set on the channel-0 sample.
- out_valid, out, 1: FIFO non-empty.
- out_ready, in, 1: consumer accepts.
- frame_cnt, out, 16: completed frames, wraps at 16'hFFFF -> 0.
- drop_cnt, out, 8: samples dropped on full FIFO, saturates at 8'hFF.
- ovf_err, out, 1: sticky, a drop occurred.
- frag_err, out, 1: sticky, resync happened mid-frame.

Behaviour:
- Reset: ch_idx=0, gap_cnt=0, FIFO empty. All outputs 0: out_valid=0, out_data=0, out_ch=0, out_sof=0, frame_cnt=0, drop_cnt=0, ovf_err=0, frag_err=0.
- Reset mid-operation flushes the FIFO; in-flight samples are lost with no error flagged.
- gap_cnt:
  - 0 on any in_flag cycle; otherwise increments, saturating at GAP_MAX.
  - When gap_cnt reaches GAP_MAX with ch_idx!=0: ch_idx<=0 and frag_err<=1.
  - When gap_cnt reaches GAP_MAX with ch_idx==0: no action.
- On in_flag:
  - Sample tagged ch=ch_idx, sof=(ch_idx==0).
  - ch_idx increments, wrapping NUM_CH-1 -> 0.
  - If ch_idx==NUM_CH-1, frame_cnt increments (whether or not the sample is masked).
- Simultaneous in_flag and timeout in the same cycle: the flag wins. The sample uses the current ch_idx, gap_cnt clears, and no resync occurs.
- Push occurs when in_flag && CH_MASK[ch_idx]. Masked samples are silently discarded and counted nowhere.
- FIFO:
  - Entry = {sof, ch, data}.
  - First-word fall-through: out_* reflect the head entry combinationally from registered storage.
  - Flag at cycle t -> out_valid=1 from cycle t+1 when the FIFO was empty.
  - Pop when out_valid && out_ready. out_* hold stable while out_valid && !out_ready.
  - Full with push and pop in the same cycle: both happen, no drop.
  - Full with push and no pop: sample dropped, drop_cnt++ (saturating), ovf_err<=1.
  - Empty: no pop regardless of out_ready.
- clr_err clears ovf_err, frag_err and drop_cnt in that cycle. If an error event occurs in the same cycle, the event wins: flag set, drop_cnt=1.
- Only pointers and count are reset; storage RAM is not reset.

Decomposition:
- Package ad_pkg: NUM_CH, DATA_W, CH_IDX_W=3, fifo entry typedef {sof, ch[2:0], data[DATA_W-1:0]}.
- Sub-module sync_fifo:
  - Parameterised width/depth, FWFT.
  - Ports: push, pop, din, dout, full, empty.
  - Simultaneous push+pop at full is legal.
- Tagging, gap timeout, counters and error logic stay in the top.

Test Plan:
- Full frame: 8 flags spaced 4 cycles, data 16'h1000..16'h1007, out_ready=1 -> 8 outputs, ch 0..7, out_sof only on 16'h1000, frame_cnt=1, no errors.
- Fragment resync: 3 flags, then 20 idle cycles, then 8 flags -> frag_err=1; next sample has ch=0, sof=1; frame_cnt=1.
- Backpressure overflow: out_ready=0, 3 frames (24 samples) -> 16 stored; drop_cnt=8, ovf_err=1. Then out_ready=1 -> 16 samples in order, ch pattern 0..7,0..7. Then clr_err -> drop_cnt=0, ovf_err=0.
- Full with concurrent push+pop: fill to 16, assert out_ready exactly on a flag cycle -> no drop, count stays 16.
- Mask: CH_MASK=8'b0000_0101, one frame -> only ch 0 and 2 appear; frame_cnt=1.
- Reset mid-frame: rst for 1 cycle after 4 flags with FIFO holding 4 -> out_valid=0 next cycle; following frame starts at ch=0; frag_err=0.
